dia_pipe_nxn: RTL and testbench

DIA_PIPE_NXN -- requirements
Module: dia_pipe_nxn

---
 rtl/dia_pipe_nxn_pkg.sv | 12 +
 rtl/dia_select_nxn.sv | 25 ++
 rtl/dia_pipe_nxn.sv | 92 +++++++++
 tb/tb_dia_pipe_nxn.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dia_pipe_nxn_pkg.sv
// Shared constants for the median-filter diagonal blocks.
// Mode encodings and result FIFO depth.
package dia_pipe_nxn_pkg;

    typedef enum logic {
        MODE_ANTI = 1'b0,
        MODE_MAIN = 1'b1
    } dia_mode_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/dia_select_nxn.sv
// Combinational diagonal pick from a packed row-major NxN window.
// Slot k of the result sits at the MSB end for k = 0.
module dia_select_nxn
    import dia_pipe_nxn_pkg::*;
#(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] window,
    input  logic                            mode,
    output logic [SIZE*DATA_WIDTH-1:0]      diagonal
);

    localparam int NC = SIZE * SIZE;

    for (genvar k = 0; k < SIZE; k++) begin : g_slot
        localparam int MAIN_IDX = NC - 1 - (k * SIZE + k);
        localparam int ANTI_IDX = NC - 1 - ((SIZE - 1 - k) * SIZE + k);
        assign diagonal[(SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH] =
            (mode == MODE_MAIN)
                ? window[MAIN_IDX*DATA_WIDTH +: DATA_WIDTH]
                : window[ANTI_IDX*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: rtl/dia_pipe_nxn.sv
// Diagonal extractor with a 2-entry result FIFO and transfer counter.
// in_ready is registered from the next occupancy, never from out_ready.
module dia_pipe_nxn
    import dia_pipe_nxn_pkg::*;
#(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                            in_mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [SIZE*DATA_WIDTH-1:0]      out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CNT_WIDTH-1:0]            out_count
);

    localparam int OW = SIZE * DATA_WIDTH;

    logic [OW-1:0]        diag;
    logic [OW-1:0]        mem_q [FIFO_DEPTH];
    logic [OW-1:0]        mem_d [FIFO_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic                 in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 push, pop;

    dia_select_nxn #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_select (
        .window   (in_data),
        .mode     (in_mode),
        .diagonal (diag)
    );

    always_comb begin
        push       = in_valid && in_ready_q;
        pop        = (occ_q != 2'd0) && out_ready;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = diag;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
        in_ready_d = (occ_d < 2'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_count = cnt_q;

endmodule

// File: tb/tb_dia_pipe_nxn.sv
// Scoreboard bench: 3x3/8-bit/16-bit-count and 5x5/4-bit/4-bit-count instances.
module tb_dia_pipe_nxn;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [71:0] a_data;
    logic        a_mode, a_valid, a_in_ready, a_out_valid, a_ordy;
    logic [23:0] a_out_data;
    logic [15:0] a_cnt;

    logic [99:0] b_data;
    logic        b_mode, b_valid, b_in_ready, b_out_valid, b_ordy;
    logic [19:0] b_out_data;
    logic [3:0]  b_cnt;

    logic [23:0] q_a[$];
    logic [19:0] q_b[$];

    localparam logic [71:0] W0 = 72'h010203040506070809;

    dia_pipe_nxn #(.SIZE(3), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_mode(a_mode),
        .in_valid(a_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_ordy), .out_count(a_cnt)
    );

    dia_pipe_nxn #(.SIZE(5), .DATA_WIDTH(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_mode(b_mode),
        .in_valid(b_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_ordy), .out_count(b_cnt)
    );

    function automatic logic [23:0] model3(input logic [71:0] w, input logic m);
        logic [23:0] r;
        int row;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            row = m ? k : 2 - k;
            r[23-8*k -: 8] = w[71-8*(row*3+k) -: 8];
        end
        return r;
    endfunction

    function automatic logic [19:0] model5(input logic [99:0] w, input logic m);
        logic [19:0] r;
        int row;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            row = m ? k : 4 - k;
            r[19-4*k -: 4] = w[99-4*(row*5+k) -: 4];
        end
        return r;
    endfunction

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    function automatic logic [99:0] rnd100();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[99:0];
    endfunction

    task automatic cyc_a(input logic v, input logic [71:0] d, input logic m,
                         input logic ordy, output logic acc, output logic xf,
                         output logic [23:0] od);
        @(negedge clk);
        a_valid = v; a_data = d; a_mode = m; a_ordy = ordy;
        #1;
        acc = v && a_in_ready;
        xf  = a_out_valid && ordy;
        od  = a_out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic v, input logic [99:0] d, input logic m,
                         input logic ordy, output logic acc, output logic xf,
                         output logic ov, output logic [19:0] od);
        @(negedge clk);
        b_valid = v; b_data = d; b_mode = m; b_ordy = ordy;
        #1;
        acc = v && b_in_ready;
        ov  = b_out_valid;
        xf  = b_out_valid && ordy;
        od  = b_out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
        tests++;
        if (a_in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", a_in_ready); end
        tests++;
        if (a_cnt !== 16'd0) begin fails++; $display("FAIL rst_count got %0d want 0", a_cnt); end
        tests++;
        if (a_out_data !== 24'd0) begin fails++; $display("FAIL rst_out_data got %h want 0", a_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (a_in_ready !== 1'b0) begin fails++; $display("FAIL rel_in_ready_early got %b want 0", a_in_ready); end
        @(posedge clk);
        #1;
        tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            fails++; $display("FAIL rel_in_ready got %b/%b want 1/1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_anti();
        logic acc, xf;
        logic [23:0] od;
        cyc_a(1'b1, W0, 1'b0, 1'b1, acc, xf, od);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL anti_accept got %b want 1", acc); end
        if (acc) q_a.push_back(24'h070503);
        cyc_a(1'b0, '0, 1'b0, 1'b1, acc, xf, od);
        tests++;
        if (!xf || q_a.size() == 0 || od !== q_a[0]) begin
            fails++; $display("FAIL anti_data valid %b got %h want %h", xf, od, 24'h070503);
        end
        if (xf && q_a.size() != 0) void'(q_a.pop_front());
        tests++;
        if (a_cnt !== 16'd1 || a_out_valid !== 1'b0) begin
            fails++; $display("FAIL anti_count got %0d/%b want 1/0", a_cnt, a_out_valid);
        end
    endtask

    task automatic test_alternate();
        logic acc, xf;
        logic [23:0] od;
        logic [3:0] modes;
        int nx;
        modes = 4'b1010;
        nx = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_a(i < 4, W0, modes[3-(i%4)], 1'b1, acc, xf, od);
            if (acc) q_a.push_back(modes[3-i] ? 24'h010509 : 24'h070503);
            if (xf) begin
                nx++;
                tests++;
                if (q_a.size() == 0 || od !== q_a[0]) begin
                    fails++; $display("FAIL alt_data got %h want %h", od, q_a.size() ? q_a[0] : 24'hx);
                end
                if (q_a.size() != 0) void'(q_a.pop_front());
            end
        end
        tests++;
        if (nx != 4 || q_a.size() != 0) begin
            fails++; $display("FAIL alt_count got %0d outputs want 4", nx);
        end
    endtask

    task automatic test_backpressure();
        logic acc, xf, got2;
        logic [23:0] od;
        logic [71:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = rnd72();
        cyc_a(1'b1, w[0], 1'b0, 1'b0, acc, xf, od);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL bp_acc0 got %b want 1", acc); end
        if (acc) q_a.push_back(model3(w[0], 1'b0));
        cyc_a(1'b1, w[1], 1'b1, 1'b0, acc, xf, od);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL bp_acc1 got %b want 1", acc); end
        if (acc) q_a.push_back(model3(w[1], 1'b1));
        cyc_a(1'b1, w[2], 1'b0, 1'b0, acc, xf, od);
        tests++;
        if (acc !== 1'b0 || a_out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_full in_ready got %b want 0", acc);
        end
        cyc_a(1'b1, w[2], 1'b0, 1'b1, acc, xf, od);
        tests++;
        if (acc !== 1'b0 || !xf || od !== q_a[0]) begin
            fails++; $display("FAIL bp_release acc %b got %h want %h", acc, od, q_a[0]);
        end
        if (xf) void'(q_a.pop_front());
        got2 = 1'b0;
        for (int i = 0; i < 10 && !(got2 && q_a.size() == 0); i++) begin
            cyc_a(!got2, w[2], 1'b0, 1'b1, acc, xf, od);
            if (acc) begin got2 = 1'b1; q_a.push_back(model3(w[2], 1'b0)); end
            if (xf) begin
                tests++;
                if (q_a.size() == 0 || od !== q_a[0]) begin
                    fails++; $display("FAIL bp_drain got %h want %h", od, q_a.size() ? q_a[0] : 24'hx);
                end
                if (q_a.size() != 0) void'(q_a.pop_front());
            end
        end
        tests++;
        if (!got2 || q_a.size() != 0) begin
            fails++; $display("FAIL bp_third accepted %b left %0d want 1/0", got2, q_a.size());
        end
    endtask

    task automatic test_stream();
        logic acc, xf, m;
        logic [23:0] od;
        logic [71:0] w;
        logic [15:0] c0, diff;
        int lows, nx;
        c0 = a_cnt; lows = 0; nx = 0;
        for (int i = 0; i < 105; i++) begin
            w = rnd72();
            m = 1'($urandom_range(0, 1));
            cyc_a(i < 100, w, m, 1'b1, acc, xf, od);
            if (i < 100 && !acc) lows++;
            if (acc) q_a.push_back(model3(w, m));
            if (xf) begin
                nx++;
                tests++;
                if (q_a.size() == 0 || od !== q_a[0]) begin
                    fails++; $display("FAIL stream_data got %h want %h", od, q_a.size() ? q_a[0] : 24'hx);
                end
                if (q_a.size() != 0) void'(q_a.pop_front());
            end
        end
        diff = a_cnt - c0;
        tests++;
        if (lows != 0) begin fails++; $display("FAIL stream_in_ready low %0d cycles want 0", lows); end
        tests++;
        if (nx != 100 || diff !== 16'd100) begin
            fails++; $display("FAIL stream_count got %0d/%0d want 100", nx, diff);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, xf;
        logic [23:0] od;
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b1, rnd72(), 1'b0, 1'b0, acc, xf, od);
        end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        tests++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            fails++; $display("FAIL mid_full got %b/%b want 1/0", a_out_valid, a_in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        tests++;
        if (a_out_valid !== 1'b0 || a_cnt !== 16'd0 || a_in_ready !== 1'b0 || a_out_data !== 24'd0) begin
            fails++;
            $display("FAIL mid_rst got v%b c%0d r%b d%h want 0", a_out_valid, a_cnt, a_in_ready, a_out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            fails++; $display("FAIL mid_recover got r%b v%b want 1/0", a_in_ready, a_out_valid);
        end
        test_anti();
    endtask

    task automatic test_wrap_b();
        logic acc, xf, ov, m;
        logic [19:0] od;
        logic [99:0] w;
        int nx;
        nx = 0;
        for (int i = 0; i < 20; i++) begin
            w = rnd100();
            m = 1'($urandom_range(0, 1));
            cyc_b(i < 17, w, m, 1'b1, acc, xf, ov, od);
            if (acc) q_b.push_back(model5(w, m));
            if (xf) begin
                nx++;
                tests++;
                if (q_b.size() == 0 || od !== q_b[0]) begin
                    fails++; $display("FAIL wrap_data got %h want %h", od, q_b.size() ? q_b[0] : 20'hx);
                end
                if (q_b.size() != 0) void'(q_b.pop_front());
            end
        end
        tests++;
        if (nx != 17 || b_cnt !== 4'd1) begin
            fails++; $display("FAIL wrap_count got %0d xfers cnt %0d want 17/1", nx, b_cnt);
        end
    endtask

    task automatic test_random_b();
        logic acc, xf, ov, m, ordy, v, hold;
        logic [19:0] od, prev;
        logic [99:0] w;
        logic [3:0] c0, c_exp;
        int nx;
        c0 = b_cnt; nx = 0; hold = 1'b0; prev = '0;
        for (int i = 0; i < 1010; i++) begin
            w = rnd100();
            m = 1'($urandom_range(0, 1));
            v = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc_b(v, w, m, ordy, acc, xf, ov, od);
            if (hold) begin
                tests++;
                if (ov !== 1'b1 || od !== prev) begin
                    fails++; $display("FAIL rnd_stable got %b/%h want 1/%h", ov, od, prev);
                end
            end
            hold = ov && !ordy;
            prev = od;
            if (acc) q_b.push_back(model5(w, m));
            if (xf) begin
                nx++;
                tests++;
                if (q_b.size() == 0 || od !== q_b[0]) begin
                    fails++; $display("FAIL rnd_data got %h want %h", od, q_b.size() ? q_b[0] : 20'hx);
                end
                if (q_b.size() != 0) void'(q_b.pop_front());
            end
        end
        c_exp = c0 + 4'(nx);
        tests++;
        if (q_b.size() != 0 || b_cnt !== c_exp) begin
            fails++; $display("FAIL rnd_end left %0d cnt %0d want 0/%0d", q_b.size(), b_cnt, c_exp);
        end
    endtask

    initial begin
        a_data = '0; a_mode = 1'b0; a_valid = 1'b0; a_ordy = 1'b0;
        b_data = '0; b_mode = 1'b0; b_valid = 1'b0; b_ordy = 1'b0;
        test_reset();
        test_anti();
        test_alternate();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_wrap_b();
        test_random_b();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests %0d", tests);
        $fatal(1);
    end

endmodule
